// File: rtl/pixel_track_ctrl.sv
// Pixel-capture sequencer for the TV tracking path: accepts one pixel
// per two cycles, drives datapath strobes, counts hits per frame.
module pixel_track_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MIN_HITS = 16,
  parameter int TIMEOUT  = 1023
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             enable,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [10:0]      pix_x,
  input  logic [10:0]      pix_y,
  input  logic             pix_match,
  output logic             ld_x,
  output logic             ld_y,
  output logic             ld_c,
  output logic             outEnable,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_hits,
  output logic             target_found,
  output logic             stall
);

  typedef enum logic {IDLE, CHECK} state_e;

  localparam logic [CNT_W-1:0] HMAX = '1;
  localparam logic [15:0]      TMO  = 16'(TIMEOUT);

  state_e           state_q, state_d;
  logic             match_q, match_d;
  logic             in_frame_q, in_frame_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [15:0]      idle_q, idle_d;
  logic             stall_q, stall_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             found_q, found_d;
  logic             accept;
  logic             frame_start;
  logic             idling;

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    in_frame_d = in_frame_q;
    hit_d      = hit_q;
    idle_d     = '0;
    done_d     = 1'b0;
    hits_d     = hits_q;
    found_d    = found_q;

    pix_ready   = resetN & enable
                & (state_q == IDLE);
    accept      = pix_ready & pix_valid;
    ld_x        = accept;
    ld_y        = accept;
    ld_c        = accept;
    outEnable   = resetN & match_q
                & (state_q == CHECK);
    frame_start = (pix_x == 11'd0)
                & (pix_y == 11'd0);
    idling      = (state_q == IDLE)
                & enable & ~pix_valid;

    unique case (state_q)
      IDLE:  if (accept) state_d = CHECK;
      CHECK: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      match_d = pix_match;
      unique case (1'b1)
        frame_start: begin
          if (in_frame_q) begin
            done_d  = 1'b1;
            hits_d  = hit_q;
            found_d = 32'(hit_q) >= 32'(MIN_HITS);
          end
          hit_d      = CNT_W'(pix_match);
          in_frame_d = 1'b1;
        end
        default: begin
          if (pix_match && hit_q != HMAX)
            hit_d = hit_q + CNT_W'(1);
        end
      endcase
    end

    // idle_cnt saturates at the timeout
    if (idling)
      idle_d = (idle_q == TMO) ? idle_q
             : idle_q + 16'd1;

    stall_d = accept ? 1'b0
            : (stall_q | (idle_d == TMO));

    frame_done   = done_q;
    frame_hits   = hits_q;
    target_found = found_q;
    stall        = stall_q;
  end

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q    <= IDLE;
      match_q    <= 1'b0;
      in_frame_q <= 1'b0;
      hit_q      <= '0;
      idle_q     <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      hits_q     <= '0;
      found_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      in_frame_q <= in_frame_d;
      hit_q      <= hit_d;
      idle_q     <= idle_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
      hits_q     <= hits_d;
      found_q    <= found_d;
    end
  end

endmodule

// File: tb/tb_pixel_track_ctrl.sv
// Bench for pixel_track_ctrl: two instances (wide counter with short
// timeout, 4-bit counter) compared against a frame-level reference.
module tb_pixel_track_ctrl;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        enable = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_match = 1'b0;
  logic [10:0] pix_x = '0;
  logic [10:0] pix_y = '0;

  logic        a_rdy, a_lx, a_ly, a_lc, a_oe;
  logic        a_fd, a_tf, a_st;
  logic [15:0] a_fh;
  logic        b_rdy, b_lx, b_ly, b_lc, b_oe;
  logic        b_fd, b_tf, b_st;
  logic [3:0]  b_fh;

  always #5 clock = ~clock;

  pixel_track_ctrl #(
    .CNT_W(16), .MIN_HITS(16), .TIMEOUT(8)
  ) dut_a (
    .clock(clock), .resetN(resetN),
    .enable(enable), .pix_valid(pix_valid),
    .pix_ready(a_rdy), .pix_x(pix_x),
    .pix_y(pix_y), .pix_match(pix_match),
    .ld_x(a_lx), .ld_y(a_ly), .ld_c(a_lc),
    .outEnable(a_oe), .frame_done(a_fd),
    .frame_hits(a_fh), .target_found(a_tf),
    .stall(a_st)
  );

  pixel_track_ctrl #(
    .CNT_W(4), .MIN_HITS(16), .TIMEOUT(1023)
  ) dut_b (
    .clock(clock), .resetN(resetN),
    .enable(enable), .pix_valid(pix_valid),
    .pix_ready(b_rdy), .pix_x(pix_x),
    .pix_y(pix_y), .pix_match(pix_match),
    .ld_x(b_lx), .ld_y(b_ly), .ld_c(b_lc),
    .outEnable(b_oe), .frame_done(b_fd),
    .frame_hits(b_fh), .target_found(b_tf),
    .stall(b_st)
  );

  int passed = 0;
  int total  = 0;

  // reference state, in frame/pixel terms
  bit busy, mm, inf, fd, tfA, tfB, stA, stB;
  int hA, hB, fhA, fhB, run;
  bit last_acc;
  int ncyc = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic cyc(input bit en, input bit v,
                     input logic [10:0] x,
                     input logic [10:0] y,
                     input bit m);
    bit rdy, acc;
    enable = en; pix_valid = v;
    pix_x = x; pix_y = y; pix_match = m;
    #3;
    rdy = resetN && en && !busy;
    acc = rdy && v;
    chk("ready", a_rdy, rdy);
    chk("ld_x", a_lx, acc);
    chk("ld_y", a_ly, acc);
    chk("ld_c", a_lc, acc);
    chk("outEnable", a_oe, resetN && busy && mm);
    chk("frame_done", a_fd, fd);
    chk("frame_hits", a_fh, fhA);
    chk("target", a_tf, tfA);
    chk("stall", a_st, stA);
    chk("b_ready", b_rdy, rdy);
    chk("b_outEnable", b_oe, resetN && busy && mm);
    chk("b_frame_done", b_fd, fd);
    chk("b_frame_hits", b_fh, fhB);
    chk("b_target", b_tf, tfB);
    chk("b_stall", b_st, stB);
    if (!resetN) begin
      busy = 0; mm = 0; inf = 0; fd = 0;
      hA = 0; hB = 0; fhA = 0; fhB = 0;
      tfA = 0; tfB = 0; run = 0;
      stA = 0; stB = 0;
    end else begin
      if (!busy && en && !v)
        run = (run < 100000) ? run + 1 : run;
      else
        run = 0;
      stA = !acc && (stA || run >= 8);
      stB = !acc && (stB || run >= 1023);
      fd = 0;
      if (acc) begin
        mm = m;
        if (x == 0 && y == 0) begin
          if (inf) begin
            fd = 1; fhA = hA; fhB = hB;
            tfA = hA >= 16; tfB = hB >= 16;
          end
          hA = m; hB = m; inf = 1;
        end else if (m) begin
          hA = (hA < 65535) ? hA + 1 : hA;
          hB = (hB < 15) ? hB + 1 : hB;
        end
      end
      busy = acc;
    end
    last_acc = acc;
    ncyc++;
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [10:0] x,
                      input logic [10:0] y,
                      input bit m);
    int n = 0;
    last_acc = 0;
    while (!last_acc && n < 8) begin
      cyc(1, 1, x, y, m);
      n++;
    end
    if (!last_acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 11'd0, 11'd0, 0);
  endtask

  function automatic logic [10:0] rx();
    return 11'($urandom_range(1, 2000));
  endfunction

  function automatic logic [10:0] ry();
    return 11'($urandom_range(0, 2047));
  endfunction

  initial begin
    int c0, nacc;
    bit hv, en, mr;
    logic [10:0] xr, yr;

    @(posedge clock); #1;
    cyc(0, 0, 11'd0, 11'd0, 0);
    enable = 1; pix_valid = 1; #1;
    chk("rst_ready", a_rdy, 0);
    chk("rst_ld", a_lx, 0);
    chk("rst_oe", a_oe, 0);
    chk("rst_hits", a_fh, 0);
    chk("rst_stall", a_st, 0);
    resetN = 1;

    send(11'd5, 11'd7, 1);
    chk("basic_oe", a_oe, 1);
    chk("basic_rdy", a_rdy, 0);
    idle(1);
    send(11'd5, 11'd7, 0);
    chk("basic_oe0", a_oe, 0);
    idle(1);

    send(11'd0, 11'd0, 0);
    for (int i = 0; i < 20; i++)
      send(rx(), ry(), (i % 7) != 0);
    send(11'd0, 11'd0, 0);
    chk("f17_done", a_fd, 1);
    chk("f17_hits", a_fh, 17);
    chk("f17_found", a_tf, 1);
    idle(1);
    chk("f17_pulse", a_fd, 0);

    for (int i = 0; i < 5; i++)
      send(rx(), ry(), i < 3);
    send(11'd0, 11'd0, 1);
    chk("f3_hits", a_fh, 3);
    chk("f3_found", a_tf, 0);

    c0 = ncyc;
    for (int i = 0; i < 6; i++)
      send(rx(), ry(), 1);
    chk("bp_rate", ncyc - c0, 12);

    send(11'd9, 11'd9, 1);
    enable = 0; #1;
    chk("en_drop_oe", a_oe, 1);
    nacc = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 11'd9, 11'd10, 0);
      nacc += int'(last_acc);
    end
    chk("en_off_noacc", nacc, 0);
    send(11'd9, 11'd10, 0);

    idle(8);
    chk("stall_pre", a_st, 0);
    idle(1);
    chk("stall_set", a_st, 1);
    idle(5);
    chk("stall_hold", a_st, 1);
    send(11'd3, 11'd3, 0);
    chk("stall_clr", a_st, 0);

    hv = 0; xr = 0; yr = 0; mr = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hv || last_acc) begin
        hv = ($urandom % 4) != 0;
        xr = ($urandom % 8 == 0) ? 11'd0 : rx();
        yr = (xr == 0) ? 11'd0 : ry();
        mr = $urandom % 2;
      end
      en = ($urandom % 8) != 0;
      cyc(en, hv, xr, yr, mr);
    end
    idle(1);

    send(11'd0, 11'd0, 0);
    for (int i = 0; i < 20; i++)
      send(rx(), ry(), 1);
    send(11'd0, 11'd0, 0);
    chk("sat_b", b_fh, 15);
    chk("sat_a", a_fh, 20);

    send(11'd0, 11'd0, 1);
    for (int i = 0; i < 3; i++)
      send(rx(), ry(), 1);
    resetN = 0;
    cyc(1, 1, 11'd4, 11'd4, 1);
    chk("mid_rst_fh", a_fh, 0);
    chk("mid_rst_tf", a_tf, 0);
    chk("mid_rst_fd", a_fd, 0);
    chk("mid_rst_st", a_st, 0);
    chk("mid_rst_oe", a_oe, 0);
    resetN = 1;
    send(11'd0, 11'd0, 1);
    chk("first_nodone", a_fd, 0);
    for (int i = 0; i < 4; i++)
      send(rx(), ry(), 1);
    send(11'd0, 11'd0, 1);
    chk("hits5", a_fh, 5);
    idle(1);
    for (int i = 0; i < 2; i++)
      send(rx(), ry(), 0);
    send(11'd0, 11'd0, 0);
    chk("carry1", a_fh, 1);
    idle(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
